// File: rtl/display_scan_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// display_scan_ctrl_if : scan controller <-> display/error-mux signal bundle
// Revision: 1.0
// ============================================================================
interface display_scan_ctrl_if;
   logic [15:0] time_digits;
   logic        err_set;
   logic        err_clr;
   logic [3:0]  err_code;
   logic [1:0]  digit_sel;
   logic [3:0]  digit_code;
   logic [3:0]  anode_n;
   logic        dp_n;
   logic        err_active;

   modport slave (
      input  time_digits, err_set, err_clr, err_code,
      output digit_sel, digit_code, anode_n, dp_n, err_active
   );

   modport master (
      output time_digits, err_set, err_clr, err_code,
      input  digit_sel, digit_code, anode_n, dp_n, err_active
   );
endinterface
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// display_scan_ctrl : 4-digit time-multiplexed scan with latched, blinking
//                     error display
// Revision: 1.0
// ============================================================================
module display_scan_ctrl #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_SCANS = 64
) (
   input  wire                  clk,
   input  wire                  rst_n,
   display_scan_ctrl_if.slave   scan_if
);

   localparam int PS_W = $clog2(REFRESH_DIV);
   localparam int FR_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(REFRESH_DIV - 1);
   localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_SCANS - 1);

   localparam logic [0:0] S_NORMAL = 1'b0;
   localparam logic [0:0] S_ERROR  = 1'b1;

   logic [PS_W-1:0] r_prescaler;
   logic [1:0]      r_digit_sel;
   logic [FR_W-1:0] r_frame_cnt;
   logic            r_blink_on;
   logic [0:0]      r_state;
   logic [3:0]      r_digit_code;
   logic [3:0]      r_anode_n;
   logic            r_dp_n;

   logic            w_tick;
   logic            w_wrap;
   logic            w_err_active;
   logic [3:0]      w_live_nib;
   logic [3:0]      w_anode_sel_n;

   assign w_tick       = (r_prescaler == PS_LAST);
   assign w_wrap       = w_tick && (r_digit_sel == 2'd3);
   assign w_err_active = (r_state == S_ERROR);

   always_comb begin
      w_live_nib    = scan_if.time_digits[3:0];
      w_anode_sel_n = 4'b1110;
      case (r_digit_sel)
         2'd0: begin w_live_nib = scan_if.time_digits[3:0];   w_anode_sel_n = 4'b1110; end
         2'd1: begin w_live_nib = scan_if.time_digits[7:4];   w_anode_sel_n = 4'b1101; end
         2'd2: begin w_live_nib = scan_if.time_digits[11:8];  w_anode_sel_n = 4'b1011; end
         default: begin w_live_nib = scan_if.time_digits[15:12]; w_anode_sel_n = 4'b0111; end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prescaler <= '0;
         r_digit_sel <= 2'd0;
      end else if (w_tick) begin
         r_prescaler <= '0;
         r_digit_sel <= r_digit_sel + 2'd1;
      end else begin
         r_prescaler <= r_prescaler + 1'b1;
      end
   end

   // err_set has priority over err_clr and over the scan-wrap blink update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_NORMAL;
         r_frame_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (scan_if.err_set) begin
         r_state     <= S_ERROR;
         r_frame_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (r_state == S_ERROR) begin
         if (scan_if.err_clr) begin
            r_state <= S_NORMAL;
         end else if (w_wrap) begin
            if (r_frame_cnt == FR_LAST) begin
               r_frame_cnt <= '0;
               r_blink_on  <= ~r_blink_on;
            end else begin
               r_frame_cnt <= r_frame_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digit_code <= 4'h0;
         r_anode_n    <= 4'b1111;
         r_dp_n       <= 1'b1;
      end else begin
         r_digit_code <= w_err_active ? scan_if.err_code : w_live_nib;
         r_anode_n    <= (w_err_active && !r_blink_on) ? 4'b1111 : w_anode_sel_n;
         r_dp_n       <= !((r_digit_sel == 2'd2) && !w_err_active);
      end
   end

   assign scan_if.digit_sel  = r_digit_sel;
   assign scan_if.digit_code = r_digit_code;
   assign scan_if.anode_n    = r_anode_n;
   assign scan_if.dp_n       = r_dp_n;
   assign scan_if.err_active = w_err_active;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_display_scan_ctrl : directed self-checking bench, REFRESH_DIV=4, BLINK_SCANS=2
// Revision: 1.0
// ============================================================================
module tb_display_scan_ctrl;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   int   ecnt;
   int   n_err;

   display_scan_ctrl_if bus();

   display_scan_ctrl #(.REFRESH_DIV(4), .BLINK_SCANS(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .scan_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // error mux model: 0->A, 1->9, 2->8, 3->7
   always_comb begin
      bus.err_code = 4'hA;
      case (bus.digit_sel)
         2'd0: bus.err_code = 4'hA;
         2'd1: bus.err_code = 4'h9;
         2'd2: bus.err_code = 4'h8;
         default: bus.err_code = 4'h7;
      endcase
   end

   // edges since reset release; digit shown after edge e is ((e-1)/4)%4
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ecnt <= 0;
      else        ecnt <= ecnt + 1;
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int shown_digit(input int e);
      return ((e - 1) / 4) % 4;
   endfunction

   function automatic logic [3:0] anode_of(input int d);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << d);
   endfunction

   task automatic test_reset();
      repeat (6) step();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.anode_n !== 4'b1111) begin errors++; $display("FAIL rst_anode: got %b exp 1111", bus.anode_n); end
      checks++; if (bus.digit_code !== 4'h0) begin errors++; $display("FAIL rst_code: got %h exp 0", bus.digit_code); end
      checks++; if (bus.dp_n !== 1'b1) begin errors++; $display("FAIL rst_dp: got %b exp 1", bus.dp_n); end
      checks++; if (bus.err_active !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", bus.err_active); end
      checks++; if (bus.digit_sel !== 2'd0) begin errors++; $display("FAIL rst_sel: got %0d exp 0", bus.digit_sel); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++; if (bus.anode_n !== 4'b1110) begin errors++; $display("FAIL first_anode: got %b exp 1110", bus.anode_n); end
      checks++; if (bus.digit_code !== 4'h4) begin errors++; $display("FAIL first_code: got %h exp 4", bus.digit_code); end
   endtask

   task automatic test_normal_scan();
      for (int i = 0; i < 20; i++) begin
         int d;
         step();
         d = shown_digit(ecnt);
         checks++; if (bus.anode_n !== anode_of(d)) begin errors++; $display("FAIL scan_anode e=%0d: got %b exp %b", ecnt, bus.anode_n, anode_of(d)); end
         checks++; if (bus.digit_code !== 4'(4 - d)) begin errors++; $display("FAIL scan_code e=%0d: got %h exp %h", ecnt, bus.digit_code, 4'(4 - d)); end
         checks++; if (bus.dp_n !== (d != 2)) begin errors++; $display("FAIL scan_dp e=%0d: got %b exp %b", ecnt, bus.dp_n, (d != 2)); end
         checks++; if (bus.err_active !== 1'b0) begin errors++; $display("FAIL scan_err e=%0d: got %b exp 0", ecnt, bus.err_active); end
      end
   endtask

   task automatic test_error_entry();
      int d;
      for (int i = 0; i < 16 && (ecnt % 16) != 15; i++) step();
      bus.err_set = 1'b1;
      step();
      bus.err_set = 1'b0;
      n_err = ecnt;
      d = shown_digit(ecnt);
      checks++; if (bus.err_active !== 1'b1) begin errors++; $display("FAIL entry_err: got %b exp 1", bus.err_active); end
      checks++; if (bus.digit_code !== 4'(4 - d)) begin errors++; $display("FAIL entry_live: got %h exp %h", bus.digit_code, 4'(4 - d)); end
      for (int i = 0; i < 16; i++) begin
         step();
         d = shown_digit(ecnt);
         checks++; if (bus.digit_code !== 4'(10 - d)) begin errors++; $display("FAIL err_code e=%0d: got %h exp %h", ecnt, bus.digit_code, 4'(10 - d)); end
         checks++; if (bus.dp_n !== 1'b1) begin errors++; $display("FAIL err_dp e=%0d: got %b exp 1", ecnt, bus.dp_n); end
         checks++; if (bus.anode_n !== anode_of(d)) begin errors++; $display("FAIL err_anode e=%0d: got %b exp %b", ecnt, bus.anode_n, anode_of(d)); end
      end
   endtask

   task automatic test_blink();
      logic [3:0] exp_an;
      int d;
      while (ecnt < n_err + 80) begin
         step();
         d = shown_digit(ecnt);
         exp_an = (ecnt >= n_err + 33 && ecnt <= n_err + 64) ? 4'b1111 : anode_of(d);
         checks++; if (bus.anode_n !== exp_an) begin errors++; $display("FAIL blink_anode e=%0d: got %b exp %b", ecnt - n_err, bus.anode_n, exp_an); end
      end
      while (ecnt < n_err + 100) step();
      checks++; if (bus.anode_n !== 4'b1111) begin errors++; $display("FAIL off_phase: got %b exp 1111", bus.anode_n); end
      bus.err_set = 1'b1;
      step();
      bus.err_set = 1'b0;
      checks++; if (bus.anode_n !== 4'b1111) begin errors++; $display("FAIL reset_blink_lag: got %b exp 1111", bus.anode_n); end
      step();
      d = shown_digit(ecnt);
      checks++; if (bus.anode_n !== anode_of(d)) begin errors++; $display("FAIL reset_blink_on: got %b exp %b", bus.anode_n, anode_of(d)); end
   endtask

   task automatic test_clear_priority();
      int d;
      bus.err_set = 1'b1;
      bus.err_clr = 1'b1;
      step();
      bus.err_set = 1'b0;
      bus.err_clr = 1'b0;
      checks++; if (bus.err_active !== 1'b1) begin errors++; $display("FAIL prio_err: got %b exp 1", bus.err_active); end
      step();
      checks++; if (bus.err_active !== 1'b1) begin errors++; $display("FAIL prio_hold: got %b exp 1", bus.err_active); end
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      checks++; if (bus.err_active !== 1'b0) begin errors++; $display("FAIL clr_err: got %b exp 0", bus.err_active); end
      for (int i = 0; i < 8; i++) begin
         step();
         d = shown_digit(ecnt);
         checks++; if (bus.digit_code !== 4'(4 - d)) begin errors++; $display("FAIL clr_code e=%0d: got %h exp %h", ecnt, bus.digit_code, 4'(4 - d)); end
         checks++; if (bus.anode_n !== anode_of(d)) begin errors++; $display("FAIL clr_anode e=%0d: got %b exp %b", ecnt, bus.anode_n, anode_of(d)); end
         checks++; if (bus.dp_n !== (d != 2)) begin errors++; $display("FAIL clr_dp e=%0d: got %b exp %b", ecnt, bus.dp_n, (d != 2)); end
      end
   endtask

   task automatic test_reset_error();
      bus.err_set = 1'b1;
      step();
      bus.err_set = 1'b0;
      repeat (40) step();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.err_active !== 1'b0) begin errors++; $display("FAIL rste_err: got %b exp 0", bus.err_active); end
      checks++; if (bus.anode_n !== 4'b1111) begin errors++; $display("FAIL rste_anode: got %b exp 1111", bus.anode_n); end
      checks++; if (bus.digit_code !== 4'h0) begin errors++; $display("FAIL rste_code: got %h exp 0", bus.digit_code); end
      checks++; if (bus.dp_n !== 1'b1) begin errors++; $display("FAIL rste_dp: got %b exp 1", bus.dp_n); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (bus.anode_n !== 4'b1110) begin errors++; $display("FAIL rste_d0_anode c=%0d: got %b exp 1110", i, bus.anode_n); end
         checks++; if (bus.digit_code !== 4'h4) begin errors++; $display("FAIL rste_d0_code c=%0d: got %h exp 4", i, bus.digit_code); end
      end
      step();
      checks++; if (bus.anode_n !== 4'b1101) begin errors++; $display("FAIL rste_d1_anode: got %b exp 1101", bus.anode_n); end
      checks++; if (bus.digit_code !== 4'h3) begin errors++; $display("FAIL rste_d1_code: got %h exp 3", bus.digit_code); end
   endtask

   initial begin
      errors          = 0;
      checks          = 0;
      n_err           = 0;
      rst_n           = 1'b0;
      bus.time_digits = 16'h1234;
      bus.err_set     = 1'b0;
      bus.err_clr     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_normal_scan();
      test_error_entry();
      test_blink();
      test_clear_priority();
      test_reset_error();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the 4-digit stopwatch display. It cycles a 2-bit digit select that drives the error-code mux's selector and the digit anodes. Per digit, it forwards either the live time nibble or the error-mux code to the seven-segment decoder. It latches the illegal-set error condition and blinks the error pattern until the error is cleared.

## Interface

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; legal range ≥ 2.
- BLINK_SCANS, 64: full 4-digit scans per blink half-period; legal range ≥ 1.

Ports:
- clk, in, 1: system clock. One clock domain.
- rst_n, in, 1: asynchronous, active-low reset.
- time_digits, in, 16: {min_tens, min_ones, sec_tens, sec_ones}; bits [3:0] are digit 0 (rightmost).
- err_set, in, 1: single-cycle pulse; an illegal time value was entered.
- err_clr, in, 1: single-cycle pulse; the error is acknowledged or cleared.
- err_code, in, 4: code returned by the error mux for the current digit_sel. This input is combinational from digit_sel.
- digit_sel, out, 2: current digit index; drives the error mux selector. 0 is the rightmost digit.
- digit_code, out, 4: code sent to the segment decoder.
- anode_n, out, 4: active-low one-hot digit enable; bit i enables digit i.
- dp_n, out, 1: active-low colon/decimal point.
- err_active, out, 1: error display mode is latched.

## Operation

Registers:
- prescaler: counts 0..REFRESH_DIV-1.
- digit_sel: 2-bit.
- frame_cnt: counts 0..BLINK_SCANS-1.
- blink_on: blink phase.
- err_active: error latch.
- Output registers: digit_code, anode_n, dp_n.

Scan:
- tick = (prescaler == REFRESH_DIV-1).
- On tick, prescaler returns to 0 and digit_sel increments modulo 4 (3 wraps to 0).
- A scan wrap is a tick while digit_sel == 3.

Output stage: every cycle, the output registers load from the current digit_sel.
- anode_n = ~(1 << digit_sel). When err_active=1 and blink_on=0, anode_n = 4'b1111 instead.
- digit_code = err_code when err_active=1; otherwise time_digits[4*digit_sel+3 : 4*digit_sel].
- dp_n = 0 when digit_sel == 2 and err_active == 0; otherwise 1. This lights the colon between minutes and seconds.

Error FSM, two states:
- NORMAL (err_active=0):
  - err_set moves to ERROR. On entry, blink_on ← 1 and frame_cnt ← 0.
- ERROR (err_active=1):
  - err_clr without err_set moves to NORMAL.
  - err_set while already in ERROR restarts blink: blink_on ← 1, frame_cnt ← 0.
  - On each scan wrap:
    - If frame_cnt == BLINK_SCANS-1: frame_cnt ← 0 and blink_on toggles.
    - Otherwise: frame_cnt increments.
- err_set and err_clr in the same cycle: err_set wins (enter or stay in ERROR, blink restarted).
- The scan never stops; the error mode only changes what is displayed.

Width rules:
- prescaler is $clog2(REFRESH_DIV) bits.
- frame_cnt is max(1, $clog2(BLINK_SCANS)) bits.
- No saturation. All counters wrap exactly at their terminal values.

## Timing

- Reset (asynchronous assert, synchronous release):
  - prescaler=0, digit_sel=0, frame_cnt=0, blink_on=1, err_active=0.
  - digit_code=4'h0, anode_n=4'b1111, dp_n=1.
- First cycle after release: anode_n=4'b1110 and digit_code=time_digits[3:0].
- digit_sel changes on the edge where tick=1.
- digit_code, anode_n and dp_n follow digit_sel one cycle later, always together. anode_n and digit_code are therefore never misaligned.
- err_set sampled at edge N: err_active=1 after edge N. The error code appears on digit_code after edge N+1.
- err_clr behaves the same way: live digits appear from edge N+1.
- Digit slot period: REFRESH_DIV cycles. Full scan: 4·REFRESH_DIV cycles.
- Blink half-period: 4·REFRESH_DIV·BLINK_SCANS cycles.
- Reset asserted mid-scan or mid-error returns all state to reset values immediately, with no clock edge needed.

## Test plan

Use REFRESH_DIV=4 and BLINK_SCANS=2, with a bench model of the error mux: sel 0→0xA, 1→0x9, 2→0x8, 3→0x7.

1. Reset behaviour:
   - Stimulus: assert rst_n=0 asynchronously mid-cycle.
   - Response: anode_n=1111, digit_code=0, dp_n=1, err_active=0 immediately.
   - After release: anode_n=1110 at the first edge.
2. Normal scan:
   - Stimulus: time_digits=16'h1234.
   - Response: (anode_n, digit_code) steps 1110/4 → 1101/3 → 1011/2 with dp_n=0 → 0111/1, 4 cycles each, then wraps to 1110/4.
3. Error entry:
   - Stimulus: one-cycle err_set.
   - Response: err_active=1 next cycle. Digit codes are 0xA, 0x9, 0x8, 0x7 for digits 0..3, and dp_n stays 1.
4. Blink:
   - Stimulus: stay in ERROR.
   - Response: after 2 full scans (32 cycles) anode_n=1111 for 32 cycles, then scanning resumes.
   - A new err_set during the off phase restores anodes on the next cycle.
5. Clear and priority:
   - Stimulus: err_set together with err_clr.
   - Response: err_active stays 1.
   - Stimulus: err_clr alone.
   - Response: err_active=0 and the 16'h1234 digits return on the next output update.
6. Reset in error mode:
   - Stimulus: assert rst_n mid-blink.
   - Response: err_active=0 and blink_on=1. After release, the normal scan starts at digit 0.
